ysyx22041405_wbu: RTL
=====================

YSYX22041405_WBU -- requirements
Module: ysyx22041405_WBU

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  MEM stage presents an instruction.
REQ-005 in_ready  out  1  WBU can accept; transfer when in_valid and in_ready both high at a rising edge.
REQ-006 in_alu_result  in  WIDTH  ALU result; bits [1:0] are the load byte offset.
REQ-007 in_pc_add4  in  WIDTH  link value for jal/jalr.
REQ-008 in_mem_rdata  in  WIDTH  raw aligned data-memory word.
REQ-009 in_wb_sel  in  2  source: 00 ALU, 01 load, 10 pc_add4, 11 no writeback.
REQ-010 in_ld_type  in  3  RV32 load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-011 in_rd  in  5  destination register index.
REQ-012 in_rf_wen  in  1  instruction writes the register file.
REQ-013 halt  in  1  freeze retirement (debug/regfile-port busy).
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_waddr  out  5  register-file write index.
REQ-016 rf_wdata  out  WIDTH  register-file write data.
REQ-017 commit  out  1  one-cycle pulse per retired instruction.
REQ-018 instret  out  64  retired-instruction counter; present only under the macro of REQ-035.

Function
REQ-019 WBU SHALL hold accepted instructions in a 2-entry FIFO (captured fields: alu_result, pc_add4, mem_rdata, wb_sel, ld_type, rd, rf_wen) with head/tail pointers and a 2-bit count.
REQ-020 in_ready SHALL equal (count != 2), with no combinational dependence on halt or in_valid.
REQ-021 Full FIFO: in_ready=0 even in a cycle where the head retires; no same-cycle bypass of a full FIFO.
REQ-022 Retire condition: count>0 and halt=0; on that rising edge the head entry is popped.
REQ-023 commit, rf_we, rf_waddr, rf_wdata SHALL be combinational from the head entry and the retire condition; commit=1 exactly when the retire condition holds.
REQ-024 rf_we = retire condition AND rf_wen AND wb_sel!=11 AND rd!=0; rf_waddr = head rd; rf_wdata is don't-care-free: 0 whenever rf_we=0.
REQ-025 Minimum latency: an instruction accepted at edge k into an empty FIFO drives rf_we/commit during the cycle after edge k (retires at edge k+1).
REQ-026 Simultaneous push and pop with count=1: count stays 1, order preserved; with count=0 push only.
REQ-027 Load data: byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]); lb/lh sign-extend, lbu/lhu zero-extend to WIDTH; lw returns word unchanged.
REQ-028 Misaligned loads: lh/lhu ignore addr[0]; lw ignores addr[1:0]; no exception raised here.
REQ-029 Undefined ld_type (011, 110, 111) SHALL return the raw word.
REQ-030 wb_sel 11 or rd=0 instructions still retire and pulse commit.
REQ-031 Pointers wrap modulo 2; FIFO order strictly first-in first-out.

Reset
REQ-032 While rst=0: count=0, pointers=0, all FIFO entries' rf_wen=0, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, commit=0, instret=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries immediately, without retiring them.
REQ-034 First acceptance possible at the first rising edge after rst deasserts.

Configuration
REQ-035 Macro YSYX22041405_INSTRET_EN: when defined, a 64-bit instret register increments by 1 on each commit, wraps 2^64-1 -> 0, output port instret exists; when undefined, no counter and no instret port, all other behaviour identical.

Verification
REQ-036 Reset, then in_valid with wb_sel=00, alu_result=0x12345678, rd=5, rf_wen=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, commit=1.
REQ-037 mem_rdata=0x80FF7F01, wb_sel=01: lb addr 3 -> 0xFFFFFF80; lbu addr 1 -> 0x0000007F; lh addr 2 -> 0xFFFF80FF; lhu addr 3 -> 0x000080FF; lw addr 1 -> 0x80FF7F01.
REQ-038 halt=1, push 3 instructions back-to-back -> first two accepted, in_ready=0 on third; release halt -> retire in order, one per cycle, third accepted after first retire.
REQ-039 rd=0 with rf_wen=1, and wb_sel=11 with rd=7 -> rf_we=0, commit=1 for each.
REQ-040 Two entries buffered under halt, drop rst -> in_ready=1, no rf_we/commit after release; with YSYX22041405_INSTRET_EN, force instret near 2^64-1 and commit twice -> wraps to 0 then 1.

Source files
------------

// File: rtl/ysyx22041405_wbu.sv
// rtl/ysyx22041405_wbu.sv - write-back unit: 2-entry retire FIFO, load extraction, optional instret (YSYX22041405_INSTRET_EN)
module ysyx22041405_wbu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic [WIDTH-1:0] in_pc_add4,
  input  logic [WIDTH-1:0] in_mem_rdata,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_ld_type,
  input  logic [4:0]       in_rd,
  input  logic             in_rf_wen,
  input  logic             halt,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             commit
`ifdef YSYX22041405_INSTRET_EN
  ,
  output logic [63:0]      instret
`endif
);

  logic [WIDTH-1:0] alu_q   [2];
  logic [WIDTH-1:0] pc4_q   [2];
  logic [WIDTH-1:0] rdata_q [2];
  logic [1:0]       sel_q   [2];
  logic [2:0]       ldt_q   [2];
  logic [4:0]       rd_q    [2];
  logic             wen_q   [2];

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;

  logic push, retire;
  logic [WIDTH-1:0] byte_sh, half_sh, ld_data, wb_data;

  // Ready depends only on occupancy, so a full FIFO never accepts even while retiring.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign retire   = (count_q != 2'd0) && !halt;

  // Pointer and occupancy next-state; push and pop together leave count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push)   tail_d = ~tail_q;
    if (retire) head_d = ~head_q;
    case ({push, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO without retiring anything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on each accepted instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        alu_q[i]   <= '0;
        pc4_q[i]   <= '0;
        rdata_q[i] <= '0;
        sel_q[i]   <= 2'b00;
        ldt_q[i]   <= 3'b000;
        rd_q[i]    <= 5'd0;
        wen_q[i]   <= 1'b0;
      end
    end else if (push) begin
      alu_q[tail_q]   <= in_alu_result;
      pc4_q[tail_q]   <= in_pc_add4;
      rdata_q[tail_q] <= in_mem_rdata;
      sel_q[tail_q]   <= in_wb_sel;
      ldt_q[tail_q]   <= in_ld_type;
      rd_q[tail_q]    <= in_rd;
      wen_q[tail_q]   <= in_rf_wen;
    end
  end

  // Load extraction from the head word; halfword offset ignores addr[0].
  always_comb begin
    byte_sh = rdata_q[head_q] >> {alu_q[head_q][1:0], 3'b000};
    half_sh = rdata_q[head_q] >> {alu_q[head_q][1], 4'b0000};
    ld_data = rdata_q[head_q];
    case (ldt_q[head_q])
      3'b000:  ld_data = {{(WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  ld_data = {{(WIDTH-16){half_sh[15]}}, half_sh[15:0]};
      3'b100:  ld_data = {{(WIDTH-8){1'b0}}, byte_sh[7:0]};
      3'b101:  ld_data = {{(WIDTH-16){1'b0}}, half_sh[15:0]};
      default: ld_data = rdata_q[head_q];
    endcase
  end

  // Write-back source select and register-file port; data is forced to zero when not writing.
  always_comb begin
    wb_data = '0;
    case (sel_q[head_q])
      2'b00:   wb_data = alu_q[head_q];
      2'b01:   wb_data = ld_data;
      2'b10:   wb_data = pc4_q[head_q];
      default: wb_data = '0;
    endcase
    commit   = retire;
    rf_we    = retire && wen_q[head_q] && (sel_q[head_q] != 2'b11) && (rd_q[head_q] != 5'd0);
    rf_waddr = rd_q[head_q];
    rf_wdata = rf_we ? wb_data : '0;
  end

`ifdef YSYX22041405_INSTRET_EN
  logic [63:0] instret_q;
  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret_q <= 64'd0;
    else if (commit) instret_q <= instret_q + 64'd1;
  end
  assign instret = instret_q;
`endif

endmodule
